// File: rtl/qa_drv_hc_ctrl_host_model_pkg.sv
// qa_drv_hc_ctrl_host_model_pkg: line widths and CTRL-frame address decode
package qa_drv_hc_ctrl_host_model_pkg;
  import qa_drv_hc_types::*;
  localparam int LINE_BITS = 512;
  localparam int REG_BITS = 64;
  typedef enum logic [1:0] {ACC_CFG, ACC_FIFO, ACC_POLL, ACC_BAD} acc_e;
  function automatic acc_e ctrl_decode(input logic [31:0] addr, input logic [27:0] base);
    return (addr[31:4] != base) ? ACC_BAD :
           (addr[3:0] == CTRL_OFFSET_CFG) ? ACC_CFG :
           (addr[3:0] == CTRL_OFFSET_FIFO_STATE) ? ACC_FIFO :
           (addr[3:0] == CTRL_OFFSET_POLL_STATE) ? ACC_POLL : ACC_BAD;
  endfunction
endpackage

// File: rtl/qa_drv_hc_types.sv
// qa_drv_hc_types: CTRL-line offsets shared by the host driver and the host model
package qa_drv_hc_types;
  localparam logic [3:0] CTRL_OFFSET_CFG = 4'd0;
  localparam logic [3:0] CTRL_OFFSET_FIFO_STATE = 4'd1;
  localparam logic [3:0] CTRL_OFFSET_POLL_STATE = 4'd2;
endpackage

// File: rtl/qa_drv_hc_ctrl_host_model_if.sv
// qa_drv_hc_ctrl_host_model_if: CCI Tx0/Tx1 requests and Rx0/Rx1 responses
interface qa_drv_hc_ctrl_host_model_if #(
  parameter int MDATA_BITS = 13
);
  logic tx0_valid;
  logic [31:0] tx0_addr;
  logic [MDATA_BITS-1:0] tx0_mdata;
  logic tx1_valid;
  logic [31:0] tx1_addr;
  logic [MDATA_BITS-1:0] tx1_mdata;
  logic [511:0] tx1_data;
  logic rx0_valid;
  logic [MDATA_BITS-1:0] rx0_mdata;
  logic [511:0] rx0_data;
  logic rx1_valid;
  logic [MDATA_BITS-1:0] rx1_mdata;
  modport master (
    output tx0_valid, tx0_addr, tx0_mdata, tx1_valid, tx1_addr, tx1_mdata, tx1_data,
    input rx0_valid, rx0_mdata, rx0_data, rx1_valid, rx1_mdata
  );
  modport slave (
    input tx0_valid, tx0_addr, tx0_mdata, tx1_valid, tx1_addr, tx1_mdata, tx1_data,
    output rx0_valid, rx0_mdata, rx0_data, rx1_valid, rx1_mdata
  );
endinterface

// File: rtl/qa_drv_hc_fixed_delay.sv
// qa_drv_hc_fixed_delay: valid+payload shift register, DEPTH cycles, flushed on reset
module qa_drv_hc_fixed_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0] <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end
  assign o_valid = r_valid[DEPTH-1];
  assign o_data = r_data[DEPTH-1];
endmodule

// File: rtl/qa_drv_hc_ctrl_host_model.sv
// qa_drv_hc_ctrl_host_model: host end of the CTRL-line protocol with emulated FIFO pointers
module qa_drv_hc_ctrl_host_model
  import qa_drv_hc_ctrl_host_model_pkg::*;
#(
  parameter int FH_IDX_BITS = 9,
  parameter int TH_IDX_BITS = 9,
  parameter int MDATA_BITS = 13,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [31:0] ctrl_frame,
  qa_drv_hc_ctrl_host_model_if.slave bus,
  input  logic host_push,
  input  logic host_pop,
  output logic push_accepted,
  output logic pop_accepted,
  output logic [FH_IDX_BITS-1:0] newest_read_line_idx,
  output logic [TH_IDX_BITS-1:0] oldest_write_idx,
  output logic cfg_valid,
  output logic [31:0] cfg_fh_max,
  output logic [31:0] cfg_th_max,
  output logic [FH_IDX_BITS-1:0] fpga_oldest_read_idx,
  output logic [TH_IDX_BITS-1:0] fpga_next_write_idx,
  output logic err_addr,
  output logic err_proto
);
  logic [REG_BITS-1:0] r_cfg_line, r_fifo_line;
  logic r_cfg_valid, r_err_addr, r_err_proto;
  logic [FH_IDX_BITS-1:0] r_newest;
  logic [TH_IDX_BITS-1:0] r_oldest;
  acc_e w_rd_acc, w_wr_acc;
  logic [REG_BITS-1:0] w_rd_line, w_wr_line;
  logic [FH_IDX_BITS-1:0] w_newest_nx;
  logic [TH_IDX_BITS-1:0] w_oldest_nx, w_old_room, w_new_room;
  logic w_cfg_wr, w_fifo_wr, w_set_addr, w_set_proto;
  logic [MDATA_BITS+REG_BITS-1:0] w_rd_out;
  logic w_unused;
  assign w_unused = ^{ctrl_frame[3:0], bus.tx1_data[LINE_BITS-1:REG_BITS]};
  assign w_rd_acc = ctrl_decode(bus.tx0_addr, ctrl_frame[31:4]);
  assign w_wr_acc = ctrl_decode(bus.tx1_addr, ctrl_frame[31:4]);
  assign w_wr_line = bus.tx1_data[REG_BITS-1:0];
  assign w_rd_line = (w_rd_acc == ACC_CFG) ? r_cfg_line :
                     (w_rd_acc == ACC_FIFO) ? r_fifo_line :
                     (w_rd_acc == ACC_POLL) ? {32'(r_oldest), 32'(r_newest)} : '0;
  // a shrinking distance from our consumer pointer means the FPGA wrote over unread entries
  assign w_old_room = fpga_next_write_idx - r_oldest;
  assign w_new_room = w_wr_line[32 +: TH_IDX_BITS] - r_oldest;
  assign w_cfg_wr = bus.tx1_valid && (w_wr_acc == ACC_CFG);
  assign w_fifo_wr = bus.tx1_valid && (w_wr_acc == ACC_FIFO) && r_cfg_valid;
  assign w_set_addr = (bus.tx0_valid && (w_rd_acc == ACC_BAD)) ||
                      (bus.tx1_valid && (w_wr_acc == ACC_BAD));
  assign w_set_proto = (bus.tx1_valid && (((w_wr_acc == ACC_FIFO) && !r_cfg_valid) || (w_wr_acc == ACC_POLL))) ||
                       (w_fifo_wr && (w_new_room < w_old_room));
  assign w_newest_nx = r_newest + FH_IDX_BITS'(1);
  assign w_oldest_nx = r_oldest + TH_IDX_BITS'(1);
  assign push_accepted = host_push && (w_newest_nx != fpga_oldest_read_idx);
  assign pop_accepted = host_pop && (r_oldest != fpga_next_write_idx);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cfg_line <= '0;
      r_fifo_line <= '0;
      r_cfg_valid <= 1'b0;
      r_newest <= '0;
      r_oldest <= '0;
      r_err_addr <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      if (w_cfg_wr) r_cfg_line <= w_wr_line;
      if (w_cfg_wr) r_cfg_valid <= 1'b1;
      if (w_fifo_wr) r_fifo_line <= w_wr_line;
      if (push_accepted) r_newest <= w_newest_nx;
      if (pop_accepted) r_oldest <= w_oldest_nx;
      r_err_addr <= r_err_addr | w_set_addr;
      r_err_proto <= r_err_proto | w_set_proto;
    end
  end
  assign newest_read_line_idx = r_newest;
  assign oldest_write_idx = r_oldest;
  assign cfg_valid = r_cfg_valid;
  assign cfg_fh_max = r_cfg_line[31:0];
  assign cfg_th_max = r_cfg_line[63:32];
  assign fpga_oldest_read_idx = r_fifo_line[FH_IDX_BITS-1:0];
  assign fpga_next_write_idx = r_fifo_line[32 +: TH_IDX_BITS];
  assign err_addr = r_err_addr;
  assign err_proto = r_err_proto;
  qa_drv_hc_fixed_delay #(.DEPTH(RD_LATENCY), .WIDTH(MDATA_BITS + REG_BITS)) u_rd_delay (
    .clk(clk),
    .reset_n(reset_n),
    .i_valid(bus.tx0_valid),
    .i_data({bus.tx0_mdata, w_rd_line}),
    .o_valid(bus.rx0_valid),
    .o_data(w_rd_out)
  );
  assign bus.rx0_mdata = w_rd_out[REG_BITS +: MDATA_BITS];
  assign bus.rx0_data = {{(LINE_BITS-REG_BITS){1'b0}}, w_rd_out[REG_BITS-1:0]};
  qa_drv_hc_fixed_delay #(.DEPTH(WR_LATENCY), .WIDTH(MDATA_BITS)) u_wr_delay (
    .clk(clk),
    .reset_n(reset_n),
    .i_valid(bus.tx1_valid),
    .i_data(bus.tx1_mdata),
    .o_valid(bus.rx1_valid),
    .o_data(bus.rx1_mdata)
  );
endmodule
